ifu_way0: RTL and testbench

IFU_WAY0 -- requirements
Module: ifu_way0

---
 rtl/ifu_way0.sv | 150 +++++++++++++++
 tb/tb_ifu_way0.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_way0.sv
// -----------------------------------------------------------------------------
// ifu_way0 -- two-entry in-order instruction fetch buffer.
//
// Takes fetch addresses from the PC unit and issues one 8-byte-aligned
// instruction memory request per accepted address. Each address owns one
// buffer entry. The entry fills when its in-order response returns and is
// presented to decode as a two-slot fetch packet. A flush discards every
// buffered packet. It also records how many outstanding responses must still
// be thrown away when they return.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   pcValid_i    in   PC unit presents a fetch address
//   pcAddr_i     in   [31:0] fetch address
//   pcReady_o    out  address consumed this cycle (request granted)
//   flush_i      in   redirect: drop buffered and in-flight packets
//   memReq_o     out  instruction memory request valid
//   memAddr_o    out  [31:0] request address, 8-byte aligned
//   memGnt_i     in   memory accepts the request this cycle
//   memRvalid_i  in   in-order response valid
//   memRdata_i   in   [63:0] packet: [31:0] slot 0, [63:32] slot 1
//   outValid_o   out  head packet valid to decode
//   outAddr_o    out  [31:0] full fetch address of the head packet
//   outInst0_o   out  [31:0] slot 0 instruction
//   outInst1_o   out  [31:0] slot 1 instruction
//   outReady_i   in   decode accepts the head packet
// -----------------------------------------------------------------------------
module ifu_way0 #(
    parameter int DEPTH = 2  // only 2 is supported: pointers are 1 bit wide
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcValid_i,
    input  logic [31:0] pcAddr_i,
    output logic        pcReady_o,
    input  logic        flush_i,
    output logic        memReq_o,
    output logic [31:0] memAddr_o,
    input  logic        memGnt_i,
    input  logic        memRvalid_i,
    input  logic [63:0] memRdata_i,
    output logic        outValid_o,
    output logic [31:0] outAddr_o,
    output logic [31:0] outInst0_o,
    output logic [31:0] outInst1_o,
    input  logic        outReady_i
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_FILLED  = 2'd2
    } entry_state_t;

    entry_state_t r_state [DEPTH];
    logic [31:0]  r_addr  [DEPTH];
    logic [63:0]  r_data  [DEPTH];
    logic         r_head;
    logic         r_tail;
    logic [1:0]   r_drop;      // stale responses still owed from before a flush

    logic [1:0]   w_alloc;
    logic [1:0]   w_npending;
    logic         w_fill_idx;
    logic         w_grant;
    logic         w_fill;
    logic         w_drop_rsp;
    logic         w_pop;
    logic [2:0]   w_owed;
    logic [1:0]   w_flush_drop;

    // Occupancy counts come only from registered state. A same-cycle pop
    // therefore cannot open space for a same-cycle grant.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_alloc    = 2'd0;
        w_npending = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_state[i] != ST_EMPTY)   w_alloc    = w_alloc + 2'd1;
            if (r_state[i] == ST_PENDING) w_npending = w_npending + 2'd1;
        end
    end

    // Entries fill in allocation order. The oldest PENDING entry is therefore
    // the head, or the entry just behind it when the head is already FILLED.
    assign w_fill_idx = (r_state[r_head] == ST_PENDING) ? r_head : ~r_head;

    assign memReq_o  = pcValid_i & ~flush_i & ~reset
                     & (({1'b0, w_alloc} + {1'b0, r_drop}) < 3'd2);
    assign memAddr_o = {pcAddr_i[31:3], 3'b000};
    assign w_grant   = memReq_o & memGnt_i;
    assign pcReady_o = w_grant;

    // A response with no PENDING entry and nothing owed is a protocol error.
    // It matches neither term below and is ignored.
    assign w_fill     = memRvalid_i & ~flush_i & (r_drop == 2'd0) & (w_npending != 2'd0);
    assign w_drop_rsp = memRvalid_i & ~flush_i & (r_drop != 2'd0);

    assign outValid_o = (r_state[r_head] == ST_FILLED) & ~flush_i & ~reset;
    assign outAddr_o  = r_addr[r_head];
    assign outInst0_o = r_data[r_head][31:0];
    assign outInst1_o = r_data[r_head][63:32];
    assign w_pop      = outValid_o & outReady_i;

    // At a flush, every PENDING entry becomes an owed response. A response
    // arriving in the flush cycle pays off one of those owed responses.
    assign w_owed       = {1'b0, r_drop} + {1'b0, w_npending};
    assign w_flush_drop = w_owed[1:0] - {1'b0, memRvalid_i && (w_owed != 3'd0)};

    // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_EMPTY;
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_drop <= 2'd0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_EMPTY;
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_drop <= w_flush_drop;
        end else begin
            // Grant targets an EMPTY entry, fill a PENDING one and pop a
            // FILLED one. These are always distinct entries, so all three can
            // update in the same cycle.
            if (w_grant) begin
                r_state[r_tail] <= ST_PENDING;
                r_tail          <= ~r_tail;
            end
            if (w_fill) begin
                r_state[w_fill_idx] <= ST_FILLED;
            end
            if (w_pop) begin
                r_state[r_head] <= ST_EMPTY;
                r_head          <= ~r_head;
            end
            if (w_drop_rsp) begin
                r_drop <= r_drop - 2'd1;
            end
        end
    end

    // NOTE: payload storage has no reset; the entry state alone decides whether its contents are meaningful.
    always_ff @(posedge clk) begin
        if (w_grant) r_addr[r_tail]     <= pcAddr_i;
        if (w_fill)  r_data[w_fill_idx] <= memRdata_i;
    end

endmodule

// File: tb/tb_ifu_way0.sv
// -----------------------------------------------------------------------------
// tb_ifu_way0 -- directed self-checking bench for ifu_way0.
//
// The bench drives inputs 1 ns after each rising edge. It samples outputs
// 1 ns later, well clear of the next edge. The bench itself plays the memory:
// it sets grant and response by hand on every step.
// -----------------------------------------------------------------------------
module tb_ifu_way0;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcValid_i;
    logic [31:0] pcAddr_i;
    logic        pcReady_o;
    logic        flush_i;
    logic        memReq_o;
    logic [31:0] memAddr_o;
    logic        memGnt_i;
    logic        memRvalid_i;
    logic [63:0] memRdata_i;
    logic        outValid_o;
    logic [31:0] outAddr_o;
    logic [31:0] outInst0_o;
    logic [31:0] outInst1_o;
    logic        outReady_i;

    int checks   = 0;
    int failures = 0;

    ifu_way0 #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .pcValid_i   (pcValid_i),
        .pcAddr_i    (pcAddr_i),
        .pcReady_o   (pcReady_o),
        .flush_i     (flush_i),
        .memReq_o    (memReq_o),
        .memAddr_o   (memAddr_o),
        .memGnt_i    (memGnt_i),
        .memRvalid_i (memRvalid_i),
        .memRdata_i  (memRdata_i),
        .outValid_o  (outValid_o),
        .outAddr_o   (outAddr_o),
        .outInst0_o  (outInst0_o),
        .outInst1_o  (outInst1_o),
        .outReady_i  (outReady_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge, then default every input.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        pcValid_i   = 1'b0;
        pcAddr_i    = 32'h0;
        flush_i     = 1'b0;
        memGnt_i    = 1'b0;
        memRvalid_i = 1'b0;
        memRdata_i  = 64'h0;
        outReady_i  = 1'b0;
    endtask

    // Let the combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset = 1'b1;
        pcValid_i = 1'b0; pcAddr_i = 32'h0; flush_i = 1'b0; memGnt_i = 1'b0;
        memRvalid_i = 1'b0; memRdata_i = 64'h0; outReady_i = 1'b0;

        // ---- reset: request, ready and valid all held low ----
        next_cycle();
        reset = 1'b1; pcValid_i = 1'b1; memGnt_i = 1'b1;
        settle();
        check("rst_memReq",   memReq_o,   1'b0);
        check("rst_pcReady",  pcReady_o,  1'b0);
        check("rst_outValid", outValid_o, 1'b0);
        next_cycle();
        reset = 1'b0;

        // ---- basic fetch: packet from address 0x0 ----
        pcValid_i = 1'b1; pcAddr_i = 32'h0; memGnt_i = 1'b1;
        settle();
        check("basic_memReq",  memReq_o,  1'b1);
        check("basic_pcReady", pcReady_o, 1'b1);
        check("basic_memAddr", memAddr_o, 32'h0);
        next_cycle();
        memRvalid_i = 1'b1; memRdata_i = 64'h00000013_00000093;
        settle();
        check("basic_no_bypass", outValid_o, 1'b0);
        next_cycle();
        outReady_i = 1'b1;
        settle();
        check("basic_outValid", outValid_o, 1'b1);
        check("basic_outAddr",  outAddr_o,  32'h0);
        check("basic_inst0",    outInst0_o, 32'h00000093);
        check("basic_inst1",    outInst1_o, 32'h00000013);
        next_cycle();
        settle();
        check("basic_popped", outValid_o, 1'b0);

        // ---- backpressure: 0x0, 0x8, 0x10 offered while decode stalls ----
        pcValid_i = 1'b1; pcAddr_i = 32'h0; memGnt_i = 1'b1;
        settle();
        check("bp_grant0", pcReady_o, 1'b1);
        next_cycle();
        pcValid_i = 1'b1; pcAddr_i = 32'h8; memGnt_i = 1'b1;
        settle();
        check("bp_grant1", pcReady_o, 1'b1);
        next_cycle();
        pcValid_i = 1'b1; pcAddr_i = 32'h10; memGnt_i = 1'b1;
        memRvalid_i = 1'b1; memRdata_i = 64'hAAAA0001_AAAA0000;
        settle();
        check("bp_full_memReq",  memReq_o,  1'b0);
        check("bp_full_pcReady", pcReady_o, 1'b0);
        next_cycle();
        pcValid_i = 1'b1; pcAddr_i = 32'h10; memGnt_i = 1'b1;
        memRvalid_i = 1'b1; memRdata_i = 64'hBBBB0001_BBBB0000;
        settle();
        check("bp_head_valid", outValid_o, 1'b1);
        check("bp_head_addr",  outAddr_o,  32'h0);
        check("bp_still_full", memReq_o,   1'b0);
        next_cycle();
        pcValid_i = 1'b1; pcAddr_i = 32'h10; memGnt_i = 1'b1; outReady_i = 1'b1;
        settle();
        check("bp_hold_addr",  outAddr_o,  32'h0);
        check("bp_hold_inst0", outInst0_o, 32'hAAAA0000);
        check("bp_pop_no_req", memReq_o,   1'b0);
        next_cycle();
        pcValid_i = 1'b1; pcAddr_i = 32'h10; memGnt_i = 1'b1;
        settle();
        check("bp_req_again",  memReq_o,   1'b1);
        check("bp_req_addr",   memAddr_o,  32'h10);
        check("bp_next_head",  outAddr_o,  32'h8);
        check("bp_next_inst1", outInst1_o, 32'hBBBB0001);
        next_cycle();
        memRvalid_i = 1'b1; memRdata_i = 64'hCCCC0001_CCCC0000; outReady_i = 1'b1;
        settle();
        check("bp_pop8", outAddr_o, 32'h8);
        next_cycle();
        outReady_i = 1'b1;
        settle();
        check("bp_last_valid", outValid_o, 1'b1);
        check("bp_last_addr",  outAddr_o,  32'h10);
        check("bp_last_inst0", outInst0_o, 32'hCCCC0000);
        next_cycle();
        settle();
        check("bp_drained", outValid_o, 1'b0);

        // ---- flush with two requests in flight ----
        pcValid_i = 1'b1; pcAddr_i = 32'h0; memGnt_i = 1'b1;
        settle();
        check("fl_grant0", pcReady_o, 1'b1);
        next_cycle();
        pcValid_i = 1'b1; pcAddr_i = 32'h8; memGnt_i = 1'b1;
        settle();
        check("fl_grant8", pcReady_o, 1'b1);
        next_cycle();
        flush_i = 1'b1; pcValid_i = 1'b1; pcAddr_i = 32'h100; memGnt_i = 1'b1;
        settle();
        check("fl_flush_req", memReq_o, 1'b0);
        next_cycle();
        pcValid_i = 1'b1; pcAddr_i = 32'h100; memGnt_i = 1'b1;
        memRvalid_i = 1'b1; memRdata_i = 64'hDEAD0000_DEAD0000;
        settle();
        check("fl_drop2_block", memReq_o,   1'b0);
        check("fl_drop2_valid", outValid_o, 1'b0);
        next_cycle();
        pcValid_i = 1'b1; pcAddr_i = 32'h100; memGnt_i = 1'b1;
        memRvalid_i = 1'b1; memRdata_i = 64'hDEAD0008_DEAD0008;
        settle();
        check("fl_drop1_grant", pcReady_o, 1'b1);
        check("fl_drop1_addr",  memAddr_o, 32'h100);
        next_cycle();
        settle();
        check("fl_stale_gone", outValid_o, 1'b0);
        memRvalid_i = 1'b1; memRdata_i = 64'h11110001_11110000;
        next_cycle();
        outReady_i = 1'b1;
        settle();
        check("fl_new_valid", outValid_o, 1'b1);
        check("fl_new_addr",  outAddr_o,  32'h100);
        check("fl_new_inst0", outInst0_o, 32'h11110000);
        next_cycle();

        // ---- flush in the same cycle as a response ----
        pcValid_i = 1'b1; pcAddr_i = 32'h200; memGnt_i = 1'b1;
        settle();
        check("fr_grant", pcReady_o, 1'b1);
        next_cycle();
        flush_i = 1'b1; memRvalid_i = 1'b1; memRdata_i = 64'hDEAD0200_DEAD0200;
        next_cycle();
        pcValid_i = 1'b1; pcAddr_i = 32'h304; memGnt_i = 1'b1;
        settle();
        check("fr_drop_zero", memReq_o,  1'b1);
        check("fr_aligned",   memAddr_o, 32'h300);
        next_cycle();
        memRvalid_i = 1'b1; memRdata_i = 64'h22220001_22220000;
        next_cycle();
        outReady_i = 1'b1;
        settle();
        check("fr_valid", outValid_o, 1'b1);
        check("fr_addr",  outAddr_o,  32'h304);
        check("fr_inst1", outInst1_o, 32'h22220001);
        next_cycle();

        // ---- reset with two FILLED entries ----
        pcValid_i = 1'b1; pcAddr_i = 32'h40; memGnt_i = 1'b1;
        next_cycle();
        pcValid_i = 1'b1; pcAddr_i = 32'h48; memGnt_i = 1'b1;
        memRvalid_i = 1'b1; memRdata_i = 64'h33330001_33330000;
        next_cycle();
        memRvalid_i = 1'b1; memRdata_i = 64'h44440001_44440000;
        next_cycle();
        settle();
        check("rs_full_valid", outValid_o, 1'b1);
        check("rs_full_addr",  outAddr_o,  32'h40);
        reset = 1'b1;
        settle();
        check("rs_in_reset", outValid_o, 1'b0);
        next_cycle();
        reset = 1'b0;
        settle();
        check("rs_after", outValid_o, 1'b0);
        // A response with nothing pending and nothing owed is ignored.
        memRvalid_i = 1'b1; memRdata_i = 64'hBAD0BAD0_BAD0BAD0;
        next_cycle();
        settle();
        check("rs_stray_ignored", outValid_o, 1'b0);
        pcValid_i = 1'b1; pcAddr_i = 32'h0; memGnt_i = 1'b1;
        settle();
        check("rs_fetch_grant", pcReady_o, 1'b1);
        next_cycle();
        memRvalid_i = 1'b1; memRdata_i = 64'h00000013_00000093;
        next_cycle();
        outReady_i = 1'b1;
        settle();
        check("rs_fetch_valid", outValid_o, 1'b1);
        check("rs_fetch_addr",  outAddr_o,  32'h0);
        check("rs_fetch_inst0", outInst0_o, 32'h00000093);
        next_cycle();
        settle();
        check("rs_fetch_pop", outValid_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
